// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg: shared FSM encoding, command encodings and default geometry for ram_burst_master
package ram_burst_pkg;
  localparam int RAM_ADDR_W = 3;
  localparam int RAM_DATA_W = 32;
  localparam int DEPTH      = 2 ** RAM_ADDR_W;
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    RD_RESP = 3'd4
  } state_t;
endpackage

// File: rtl/ram_burst_addr_gen.sv
// ram_burst_addr_gen: burst address/beat counter with wrap and last-beat flag
// Ports: clk, rst (async, active-high); i_load latches i_addr/i_len; i_step advances one beat;
//        o_addr current RAM address; o_last high while on the final beat.
module ram_burst_addr_gen #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_cur, r_beats, r_len;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur   <= '0;
      r_beats <= '0;
      r_len   <= '0;
    end else if (i_load) begin
      r_cur   <= i_addr;
      r_beats <= '0;
      r_len   <= i_len;
    end else if (i_step) begin
      r_cur   <= r_cur + 1'b1;
      r_beats <= r_beats + 1'b1;
    end
  end
  assign o_addr = r_cur;
  assign o_last = r_beats == r_len;
endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a single-port RAM with registered read data
// Ports: clk, rst (async, active-high); cmd_* burst command channel (valid/ready, cmd_len = beats-1);
//        wr_* write beat stream in; rd_* read beat stream out; busy; ram_* RAM port.
// Build option RAM_WRAP_CHK_EN: commands whose burst would cross the top address are
//        consumed but dropped with a one-cycle cmd_err pulse; otherwise addresses wrap and cmd_err is 0.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              cmd_err,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wenable,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  state_t r_state, w_state_nx;
  logic w_idle_rdy, w_load, w_step, w_cap, w_last, w_wrap_err;
  logic [DATA_W-1:0] r_rd_data;
  ram_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_addr (cmd_addr),
    .i_len  (cmd_len),
    .o_addr (ram_addr),
    .o_last (w_last)
  );
`ifdef RAM_WRAP_CHK_EN
  logic [ADDR_W:0] w_end;
  logic r_cmd_err;
  // a carry out of the start+len sum means the burst would pass the top address
  assign w_end      = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign w_wrap_err = w_end[ADDR_W];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cmd_err <= 1'b0;
    else     r_cmd_err <= w_load & w_wrap_err;
  end
  assign cmd_err = r_cmd_err;
`else
  assign w_wrap_err = 1'b0;
  assign cmd_err    = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_cap) r_rd_data <= ram_dout;
    end
  end
  always_comb begin
    w_state_nx  = r_state;
    w_idle_rdy  = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_cap       = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    ram_wenable = 1'b0;
    ram_din     = '0;
    case (r_state)
      IDLE: begin
        w_idle_rdy = 1'b1;
        w_load     = cmd_valid;
        if (cmd_valid && !w_wrap_err) w_state_nx = (cmd_write == CMD_WR) ? WR : RD_ADDR;
      end
      WR: begin
        wr_ready    = 1'b1;
        ram_din     = wr_data;
        ram_wenable = wr_valid;
        w_step      = wr_valid;
        if (wr_valid && w_last) w_state_nx = IDLE;
      end
      RD_ADDR: w_state_nx = RD_CAP;
      RD_CAP: begin
        w_cap      = 1'b1;
        w_state_nx = RD_RESP;
      end
      RD_RESP: begin
        rd_valid = 1'b1;
        w_step   = rd_ready & ~w_last;
        if (rd_ready) w_state_nx = w_last ? IDLE : RD_ADDR;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  // ready is withheld while reset is asserted so no command is seen as taken during reset
  assign cmd_ready = w_idle_rdy & ~rst;
  assign busy      = r_state != IDLE;
  assign rd_data   = r_rd_data;
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed scoreboard bench for ram_burst_master with a behavioural 8x32 RAM
module tb_ram_burst_master;
  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_write, cmd_err;
  logic [2:0]  cmd_addr, cmd_len, ram_addr;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, busy, ram_wenable;
  logic [31:0] wr_data, rd_data, ram_din, ram_dout;
  logic [31:0] mem [8] = '{32'd52, 32'd78, 32'd95, 32'd47, 32'd102, 32'd80, 32'd82, 32'd118};
  logic [31:0] exp_mem [8] = '{32'd52, 32'd78, 32'd95, 32'd47, 32'd102, 32'd80, 32'd82, 32'd118};
  logic [31:0] sb [$];
  logic [34:0] wlog [$];
  int n_checks = 0;
  int n_fail = 0;
  int wen_cnt = 0;
  always #5 clk = ~clk;
  ram_burst_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .busy(busy), .ram_addr(ram_addr), .ram_wenable(ram_wenable),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );
  always @(posedge clk) begin
    if (ram_wenable) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ram_wenable) begin
      wen_cnt++;
      wlog.push_back({ram_addr, ram_din});
    end
    if (!rst && rd_valid && rd_ready) begin
      if (sb.size() == 0) chk("rd_unexpected", rd_data, 0);
      else chk("rd_data", rd_data, sb.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue_cmd(input logic w, input logic [2:0] a, input logic [2:0] l);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic write_beat(input logic [31:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    chk("wr_ready", wr_ready, 1);
    tick();
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      tick();
      n++;
    end
    chk("rd_drain", sb.size(), 0);
    chk("idle_after_burst", busy, 0);
  endtask
  task automatic push_rd(input int a, input int l);
    for (int i = 0; i <= l; i++) sb.push_back(exp_mem[(a + i) % 8]);
  endtask
  task automatic chk_mem();
    for (int i = 0; i < 8; i++) chk($sformatf("mem[%0d]", i), mem[i], exp_mem[i]);
  endtask
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_busy", busy, 0);
    chk("rel_rd_valid", rd_valid, 0);
    chk("rel_wr_ready", wr_ready, 0);
    chk("rel_wenable", ram_wenable, 0);
    chk("rel_ram_addr", ram_addr, 0);
    chk("rel_ram_din", ram_din, 0);
    chk("rel_rd_data", rd_data, 0);
    chk("rel_cmd_err", cmd_err, 0);
    // read 2..4 with rd_ready high; rd_valid must rise two cycles after acceptance
    rd_ready = 1'b1;
    wen_cnt = 0;
    sb.push_back(32'd95); sb.push_back(32'd47); sb.push_back(32'd102);
    issue_cmd(1'b0, 3'd2, 3'd2);
    chk("rdA_busy", busy, 1);
    chk("rdA_cmd_ready", cmd_ready, 0);
    tick();
    chk("rdA_lat1", rd_valid, 0);
    tick();
    chk("rdA_lat2", rd_valid, 1);
    drain();
    chk("rdA_no_wen", wen_cnt, 0);
`ifndef RAM_WRAP_CHK_EN
    // wrapping write 6,7,0,1 then read back
    issue_cmd(1'b1, 3'd6, 3'd3);
    chk("wrB_cmd_err", cmd_err, 0);
    write_beat(32'd11); write_beat(32'd22); write_beat(32'd33); write_beat(32'd44);
    wr_valid = 1'b0;
    exp_mem[6] = 32'd11; exp_mem[7] = 32'd22; exp_mem[0] = 32'd33; exp_mem[1] = 32'd44;
    tick();
    chk("wrB_busy", busy, 0);
    chk_mem();
    push_rd(6, 3);
    issue_cmd(1'b0, 3'd6, 3'd3);
    drain();
`else
    // wrapping command is consumed and dropped with a single cmd_err pulse
    wen_cnt = 0;
    issue_cmd(1'b1, 3'd6, 3'd3);
    chk("err_pulse", cmd_err, 1);
    chk("err_busy", busy, 0);
    wr_valid = 1'b1;
    wr_data = 32'hdead;
    tick();
    chk("err_pulse_end", cmd_err, 0);
    chk("err_wr_ready", wr_ready, 0);
    tick();
    wr_valid = 1'b0;
    chk("err_no_wen", wen_cnt, 0);
    chk_mem();
    push_rd(4, 3);
    issue_cmd(1'b0, 3'd4, 3'd3);
    chk("ok_cmd_err", cmd_err, 0);
    drain();
`endif
    // write with wr_valid toggling: one RAM write per valid beat, exactly four
    wlog.delete();
    issue_cmd(1'b1, 3'd0, 3'd3);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data = 32'd100 + 32'(i);
      tick();
      wr_valid = 1'b0;
      tick();
      exp_mem[i] = 32'd100 + 32'(i);
    end
    chk("wrC_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [34:0] e;
      e = {i[2:0], 32'd100 + 32'(i)};
      if (i < wlog.size()) chk($sformatf("wrC_beat%0d", i), wlog[i], e);
    end
    chk("wrC_busy", busy, 0);
    chk_mem();
    // read stalled by rd_ready low: data, valid and address must hold
    rd_ready = 1'b0;
    issue_cmd(1'b0, 3'd5, 3'd1);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rd_valid", rd_valid, 1);
      chk("stall_rd_data", rd_data, exp_mem[5]);
      chk("stall_ram_addr", ram_addr, 5);
      tick();
    end
    push_rd(5, 1);
    rd_ready = 1'b1;
    drain();
    // reset in the middle of a 4-beat write after two beats
    wlog.delete();
    issue_cmd(1'b1, 3'd2, 3'd3);
    write_beat(32'd200);
    write_beat(32'd201);
    exp_mem[2] = 32'd200; exp_mem[3] = 32'd201;
    wr_data = 32'd202;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wenable", ram_wenable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_din", ram_din, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    wr_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_writes", wlog.size(), 2);
    chk_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
